// File: rtl/vc_fifo.sv
// Virtual-channel FIFO: circular buffer with registered read port and registered status flags.
// Optional sticky illegal-access flag is built only when VC_FIFO_ERR_EN is defined.
module vc_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   afull_thr,
    input  logic [ADDR_WIDTH:0]   aempty_thr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_pause,
    output logic                  fifo_almost_empty,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  pause_q, pause_d;
    logic                  aempty_q, aempty_d;

    logic                  pop_acc;
    logic                  push_acc;

    // Acceptance uses the registered flags, so no push/pop path reaches the flags.
    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    assign pop_acc  = pop & ~empty_q;
    assign push_acc = push & (~full_q | pop_acc);

    // NOTE: every signal gets a default before any branch so always_comb never infers a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = pop_acc;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem_q[rd_ptr_q];
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d   = (count_d == DEPTH_CNT);
        empty_d  = (count_d == '0);
        pause_d  = (count_d >= afull_thr);
        aempty_d = (count_d != '0) && (count_d <= aempty_thr);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            pause_q     <= 1'b0;
            aempty_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            pause_q     <= pause_d;
            aempty_q    <= aempty_d;
        end
    end

    // NOTE: storage has no reset; a word is only read after a push has written it.
    always_ff @(posedge clk) begin
        if (reset_L && push_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef VC_FIFO_ERR_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q | (push & ~push_acc) | (pop & ~pop_acc);
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign data_out          = data_out_q;
    assign valid_out         = valid_out_q;
    assign fifo_full         = full_q;
    assign fifo_empty        = empty_q;
    assign fifo_pause        = pause_q;
    assign fifo_almost_empty = aempty_q;

endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench for vc_fifo: directed vector table, hand sequences and a
// queue-model scoreboard under random traffic.
module tb_vc_fifo;

    localparam int DW    = 6;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef VC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_L;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [AW:0]   afull_thr;
    logic [AW:0]   aempty_thr;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pause;
    logic          fifo_almost_empty;
    logic          error;

    vc_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .reset_L           (reset_L),
        .push              (push),
        .data_in           (data_in),
        .pop               (pop),
        .afull_thr         (afull_thr),
        .aempty_thr        (aempty_thr),
        .data_out          (data_out),
        .valid_out         (valid_out),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_pause        (fifo_pause),
        .fifo_almost_empty (fifo_almost_empty),
        .error             (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] mdl[$];
    logic [DW-1:0] exp_q[$];
    int            m_cnt;
    logic [DW-1:0] e_dout;
    bit            e_valid, e_full, e_empty, e_pause, e_ae, m_err;

    typedef struct {
        bit            rst_n;
        bit            push;
        logic [DW-1:0] din;
        bit            pop;
        logic [AW:0]   afull;
        logic [AW:0]   aempty;
        bit            valid;
        logic [DW-1:0] dout;
        bit            full;
        bit            empty;
        bit            pause;
        bit            ae;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_outputs();
        logic [DW-1:0] w;
        check("valid_out", valid_out, e_valid);
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("sb_data", data_out, w);
            end
        end else begin
            if (e_valid && exp_q.size() != 0) void'(exp_q.pop_front());
            check("dout_hold", data_out, e_dout);
        end
        check("fifo_full", fifo_full, e_full);
        check("fifo_empty", fifo_empty, e_empty);
        check("fifo_pause", fifo_pause, e_pause);
        check("fifo_almost_empty", fifo_almost_empty, e_ae);
        check("error", error, m_err);
    endtask

    task automatic step(input bit p, input logic [DW-1:0] d, input bit q);
        bit pa, wa;
        pa = q && (m_cnt != 0);
        wa = p && (m_cnt < DEPTH || pa);
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        if (ERR_EN && ((p && !wa) || (q && !pa))) m_err = 1'b1;
        if (pa) begin
            e_dout = mdl.pop_front();
            exp_q.push_back(e_dout);
        end
        if (wa) mdl.push_back(d);
        e_valid = pa;
        m_cnt   = mdl.size();
        e_full  = (m_cnt == DEPTH);
        e_empty = (m_cnt == 0);
        e_pause = (m_cnt >= int'(afull_thr));
        e_ae    = (m_cnt != 0) && (m_cnt <= int'(aempty_thr));
        #1;
        push = 1'b0;
        pop  = 1'b0;
        compare_outputs();
    endtask

    task automatic do_reset(input bit p, input bit q);
        reset_L = 1'b0;
        push    = p;
        pop     = q;
        data_in = DW'($urandom);
        @(posedge clk);
        mdl.delete();
        exp_q.delete();
        m_cnt   = 0;
        e_dout  = '0;
        e_valid = 1'b0;
        e_full  = 1'b0;
        e_empty = 1'b1;
        e_pause = 1'b0;
        e_ae    = 1'b0;
        m_err   = 1'b0;
        #1;
        reset_L = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        compare_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_L    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        data_in    = '0;
        afull_thr  = 5'd3;
        aempty_thr = 5'd1;

        //            rst push din    pop afull aempty  valid dout  full empty pause ae
        vecs[0]  = '{1'b0, 1'b1, 6'h3F, 1'b1, 5'd3, 5'd1, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 6'h05, 1'b0, 5'd3, 5'd1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 6'h0A, 1'b0, 5'd3, 5'd1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 6'h0F, 1'b1, 5'd3, 5'd1, 1'b1, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 6'h11, 1'b0, 5'd3, 5'd1, 1'b0, 6'h05, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 6'h00, 1'b0, 5'd3, 5'd1, 1'b0, 6'h05, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 6'h00, 1'b1, 5'd3, 5'd1, 1'b1, 6'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 6'h00, 1'b1, 5'd3, 5'd1, 1'b1, 6'h0F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 6'h00, 1'b1, 5'd3, 5'd1, 1'b1, 6'h11, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 6'h00, 1'b1, 5'd3, 5'd1, 1'b0, 6'h11, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 6'h22, 1'b1, 5'd3, 5'd1, 1'b0, 6'h11, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 6'h00, 1'b0, 5'd0, 5'd1, 1'b0, 6'h11, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 6'h00, 1'b1, 5'd0, 5'd1, 1'b1, 6'h22, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 6'h00, 1'b0, 5'd5, 5'd0, 1'b0, 6'h22, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            reset_L    = vecs[i].rst_n;
            push       = vecs[i].push;
            data_in    = vecs[i].din;
            pop        = vecs[i].pop;
            afull_thr  = vecs[i].afull;
            aempty_thr = vecs[i].aempty;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), valid_out, vecs[i].valid);
            check($sformatf("vec%0d_dout", i), data_out, vecs[i].dout);
            check($sformatf("vec%0d_full", i), fifo_full, vecs[i].full);
            check($sformatf("vec%0d_empty", i), fifo_empty, vecs[i].empty);
            check($sformatf("vec%0d_pause", i), fifo_pause, vecs[i].pause);
            check($sformatf("vec%0d_aempty", i), fifo_almost_empty, vecs[i].ae);
        end
        push = 1'b0;
        pop  = 1'b0;

        // Fill to full, drain in order
        afull_thr  = 5'd16;
        aempty_thr = 5'd0;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, DW'(i + 1), 1'b0);
        check("fill16_full", fifo_full, 1);
        check("fill16_empty", fifo_empty, 0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1);
            check("drain16_data", data_out, i + 1);
            check("drain16_valid", valid_out, 1);
        end
        check("drain16_empty", fifo_empty, 1);

        // Simultaneous push and pop while full
        for (int i = 0; i < 16; i++) step(1'b1, DW'(i + 1), 1'b0);
        step(1'b1, 6'h2A, 1'b1);
        check("full_simul_dout", data_out, 6'h01);
        check("full_simul_full", fifo_full, 1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1);
            check("full_simul_order", data_out, (i < 15) ? i + 2 : 32'h2A);
        end

        // Almost-full / almost-empty thresholds
        do_reset(1'b0, 1'b0);
        afull_thr  = 5'd12;
        aempty_thr = 5'd2;
        for (int i = 0; i < 11; i++) step(1'b1, DW'($urandom), 1'b0);
        check("pause_at11", fifo_pause, 0);
        step(1'b1, DW'($urandom), 1'b0);
        check("pause_at12", fifo_pause, 1);
        step(1'b0, '0, 1'b1);
        check("pause_at11_after_pop", fifo_pause, 0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        check("aempty_at3", fifo_almost_empty, 0);
        step(1'b0, '0, 1'b1);
        check("aempty_at2", fifo_almost_empty, 1);

        // Illegal pop on empty and error stickiness
        do_reset(1'b0, 1'b0);
        step(1'b0, '0, 1'b1);
        check("bad_pop_valid", valid_out, 0);
        check("bad_pop_error", error, ERR_EN);
        step(1'b1, 6'h07, 1'b0);
        step(1'b1, 6'h08, 1'b1);
        step(1'b0, '0, 1'b1);
        check("error_sticky", error, ERR_EN);
        do_reset(1'b0, 1'b0);
        check("error_cleared", error, 0);

        // Reset in the middle of traffic
        afull_thr  = 5'd10;
        aempty_thr = 5'd1;
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 9), 1'b0);
        do_reset(1'b1, 1'b1);
        check("midrst_empty", fifo_empty, 1);
        check("midrst_valid", valid_out, 0);
        step(1'b1, 6'h3F, 1'b0);
        step(1'b0, '0, 1'b1);
        check("midrst_readback", data_out, 6'h3F);
        check("midrst_readback_valid", valid_out, 1);

        // Random traffic against the queue model
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            int pp, qp;
            if (i % 100 == 0) begin
                afull_thr  = 5'($urandom_range(0, 16));
                aempty_thr = 5'($urandom_range(0, 16));
            end
            pp = (i < 250) ? 75 : (i < 500) ? 30 : 55;
            qp = (i < 250) ? 35 : (i < 500) ? 75 : 50;
            step($urandom_range(0, 99) < pp, DW'($urandom), $urandom_range(0, 99) < qp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_fifo.md
VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 6: width of every stored word.
REQ-002 Parameter ADDR_WIDTH, default 4: depth is 2**ADDR_WIDTH words (16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 push  input  1  write request; data_in stored when accepted.
REQ-006 data_in  input  DATA_WIDTH  write word.
REQ-007 pop  input  1  read request from the downstream stage.
REQ-008 afull_thr  input  ADDR_WIDTH+1  almost-full threshold, in words.
REQ-009 aempty_thr  input  ADDR_WIDTH+1  almost-empty threshold, in words.
REQ-010 data_out  output  DATA_WIDTH  registered read word.
REQ-011 valid_out  output  1  data_out holds a word popped on the previous edge.
REQ-012 fifo_full  output  1  count == 2**ADDR_WIDTH.
REQ-013 fifo_empty  output  1  count == 0.
REQ-014 fifo_pause  output  1  almost-full flag; drives the input flow controller's pause input for this VC.
REQ-015 fifo_almost_empty  output  1  count <= aempty_thr, and count != 0.
REQ-016 error  output  1  sticky illegal-access flag (see Configuration).

Function
REQ-017 Circular buffer with write pointer, read pointer and an occupancy counter of width ADDR_WIDTH+1; pointers wrap modulo depth with no gap.
REQ-018 A push is accepted iff push=1 and (fifo_full=0 or an accepted pop occurs on the same edge).
REQ-019 A pop is accepted iff pop=1 and fifo_empty=0.
REQ-020 A push and a pop on the same edge with 0 < count < depth are both accepted; count is unchanged.
REQ-021 Push and pop on the same edge when empty: the push is accepted, the pop is rejected, and valid_out=0 on the next cycle; there is no write-through bypass.
REQ-022 Push and pop on the same edge when full: both are accepted; count stays at depth.
REQ-023 Read latency is one cycle: on an edge that accepts a pop, data_out is loaded with the oldest word and valid_out=1; otherwise valid_out=0 and data_out holds its value.
REQ-024 Status flags fifo_full, fifo_empty, fifo_pause and fifo_almost_empty are registered and reflect count after the current edge, with no combinational path from push or pop.
REQ-025 fifo_pause=1 iff count >= afull_thr; afull_thr=0 forces fifo_pause=1.
REQ-026 Thresholds are sampled continuously; a threshold change takes effect on the next edge.
REQ-027 A rejected push or pop leaves pointers, count and stored data unchanged.

Reset
REQ-028 While reset_L=0 at an edge, the block clears pointers and count to 0, data_out to 0, valid_out to 0 and error to 0, and sets fifo_empty=1, fifo_full=0, fifo_pause=0 and fifo_almost_empty=0.
REQ-029 A reset asserted mid-operation discards all stored words; push and pop are ignored on that edge.
REQ-030 Memory contents need not be cleared; they are unobservable until rewritten.

Configuration
REQ-031 Macro VC_FIFO_ERR_EN defined: error is set on the first edge with a rejected push (push while full, no pop) or a rejected pop (pop while empty), and it stays at 1 until reset.
REQ-032 Macro VC_FIFO_ERR_EN undefined: error is tied to 0 and no error logic is built; the accept/reject behaviour is unchanged.

Verification
REQ-033 Reset, then push 0x01..0x10 on 16 consecutive edges -> fifo_full=1 after the 16th edge and fifo_empty=0; then pop 16 times -> data_out reads 0x01..0x10 in order, with valid_out=1 on each cycle after a pop.
REQ-034 Set afull_thr=12, aempty_thr=2, then push 12 words -> fifo_pause rises on the edge of the 12th push; pop 1 word -> fifo_pause falls; pop down to 2 words -> fifo_almost_empty=1.
REQ-035 With full FIFO, push 0x2A and pop on the same edge -> count stays 16, data_out=0x01, and 0x2A is read last.
REQ-036 With VC_FIFO_ERR_EN defined, pop when empty -> valid_out=0 and error=1, which persists after later legal traffic; reset -> error=0. Without the macro, the same stimulus -> error stays 0.
REQ-037 With 5 words stored, drive reset_L=0 for one edge while push=1 and pop=1 -> fifo_empty=1, count 0, valid_out=0; the next push of 0x3F followed by a pop reads 0x3F.
REQ-038 Run 1000 cycles of random push/pop against a reference queue model -> no data mismatch, and the flags always agree with the model count.
